aes_core_ctrl: RTL and testbench

Top-level sequencer for the AES core.
- Accepts init (key expansion) and next (block processing) commands.
- Drives the key memory init and the encipher/decipher next strobes, and tracks their ready signals.
- Owns the shared 32-bit S-box select.
- Reports core ready, result valid and command errors.

---
 rtl/aes_core_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_aes_core_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_core_ctrl.sv
// AES core top-level sequencer: key expansion / block command FSM, strobes, S-box ownership.
// Optional watchdog on the wait states is compiled in with `define AES_CTRL_WDOG_EN.
module aes_core_ctrl #(
  parameter int unsigned WDOG_CYCLES = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic init,
  input  logic next,
  input  logic encdec,
  input  logic keylen,
  output logic key_init,
  input  logic key_ready,
  output logic enc_next,
  input  logic enc_ready,
  output logic dec_next,
  input  logic dec_ready,
  output logic keylen_q,
  output logic sbox_sel,
  output logic ready,
  output logic key_valid,
  output logic result_valid,
  output logic cmd_err,
  output logic timeout
);

  typedef enum logic [2:0] {
    IDLE,
    KEY_START,
    KEY_WAIT,
    BLK_START,
    BLK_WAIT,
    DONE
  } state_e;

  state_e state_q, state_d;
  logic   key_init_q, key_init_d;
  logic   enc_next_q, enc_next_d;
  logic   dec_next_q, dec_next_d;
  logic   ready_q, ready_d;
  logic   key_valid_q, key_valid_d;
  logic   result_valid_q, result_valid_d;
  logic   cmd_err_q, cmd_err_d;
  logic   encdec_q, encdec_d;
  logic   keylen_d;
  logic   blk_done;

`ifdef AES_CTRL_WDOG_EN
  logic [7:0] wdog_q, wdog_d;
  logic       timeout_q, timeout_d;
`endif

  assign blk_done = encdec_q ? enc_ready : dec_ready;

  always_comb begin
    state_d        = state_q;
    key_init_d     = 1'b0;
    enc_next_d     = 1'b0;
    dec_next_d     = 1'b0;
    cmd_err_d      = 1'b0;
    ready_d        = ready_q;
    key_valid_d    = key_valid_q;
    result_valid_d = result_valid_q;
    encdec_d       = encdec_q;
    keylen_d       = keylen_q;
`ifdef AES_CTRL_WDOG_EN
    wdog_d         = wdog_q;
    timeout_d      = timeout_q;
`endif

    case (state_q)
      IDLE: begin
        if (init) begin
          keylen_d       = keylen;
          key_init_d     = 1'b1;
          key_valid_d    = 1'b0;
          result_valid_d = 1'b0;
          ready_d        = 1'b0;
          cmd_err_d      = next;
          state_d        = KEY_START;
        end else if (next) begin
          if (!key_valid_q) begin
            cmd_err_d = 1'b1;
          end else begin
            encdec_d       = encdec;
            result_valid_d = 1'b0;
            ready_d        = 1'b0;
            enc_next_d     = encdec;
            dec_next_d     = !encdec;
            state_d        = BLK_START;
          end
        end
      end
      KEY_START: state_d = KEY_WAIT;
      KEY_WAIT: begin
        if (key_ready) begin
          key_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      BLK_START: state_d = BLK_WAIT;
      BLK_WAIT: begin
        if (blk_done) begin
          result_valid_d = 1'b1;
          state_d        = DONE;
        end
      end
      DONE: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && (init || next)) begin
      cmd_err_d = 1'b1;
    end

`ifdef AES_CTRL_WDOG_EN
    // Abort only when still waiting; a ready arriving on the final count wins.
    if (state_q == KEY_WAIT || state_q == BLK_WAIT) begin
      wdog_d = wdog_q + 8'd1;
      if (state_d == state_q && ({1'b0, wdog_q} + 9'd1) == 9'(WDOG_CYCLES)) begin
        state_d   = IDLE;
        ready_d   = 1'b1;
        timeout_d = 1'b1;
      end
    end
    if ((state_d == KEY_WAIT || state_d == BLK_WAIT) && state_d != state_q) begin
      wdog_d = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      key_init_q     <= 1'b0;
      enc_next_q     <= 1'b0;
      dec_next_q     <= 1'b0;
      ready_q        <= 1'b1;
      key_valid_q    <= 1'b0;
      result_valid_q <= 1'b0;
      cmd_err_q      <= 1'b0;
      encdec_q       <= 1'b0;
      keylen_q       <= 1'b0;
`ifdef AES_CTRL_WDOG_EN
      wdog_q         <= '0;
      timeout_q      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      key_init_q     <= key_init_d;
      enc_next_q     <= enc_next_d;
      dec_next_q     <= dec_next_d;
      ready_q        <= ready_d;
      key_valid_q    <= key_valid_d;
      result_valid_q <= result_valid_d;
      cmd_err_q      <= cmd_err_d;
      encdec_q       <= encdec_d;
      keylen_q       <= keylen_d;
`ifdef AES_CTRL_WDOG_EN
      wdog_q         <= wdog_d;
      timeout_q      <= timeout_d;
`endif
    end
  end

  assign key_init     = key_init_q;
  assign enc_next     = enc_next_q;
  assign dec_next     = dec_next_q;
  assign ready        = ready_q;
  assign key_valid    = key_valid_q;
  assign result_valid = result_valid_q;
  assign cmd_err      = cmd_err_q;
  assign sbox_sel     = encdec_q && (state_q == BLK_START || state_q == BLK_WAIT);

`ifdef AES_CTRL_WDOG_EN
  assign timeout = timeout_q;
`else
  logic [7:0] unused_wdog;
  assign unused_wdog = 8'(WDOG_CYCLES);
  assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_aes_core_ctrl.sv
// Directed bench for aes_core_ctrl: expectations queued at stimulus time, popped when results appear.
module tb_aes_core_ctrl;

`ifdef AES_CTRL_WDOG_EN
  localparam int unsigned ENC_WAIT = 15;
`else
  localparam int unsigned ENC_WAIT = 50;
`endif

  logic clk = 1'b0;
  logic reset_n, init, next, encdec, keylen, key_ready, enc_ready, dec_ready;
  logic key_init, enc_next, dec_next, keylen_q, sbox_sel, ready;
  logic key_valid, result_valid, cmd_err, timeout;

  always #5 clk = ~clk;

  aes_core_ctrl #(.WDOG_CYCLES(20)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .init         (init),
    .next         (next),
    .encdec       (encdec),
    .keylen       (keylen),
    .key_init     (key_init),
    .key_ready    (key_ready),
    .enc_next     (enc_next),
    .enc_ready    (enc_ready),
    .dec_next     (dec_next),
    .dec_ready    (dec_ready),
    .keylen_q     (keylen_q),
    .sbox_sel     (sbox_sel),
    .ready        (ready),
    .key_valid    (key_valid),
    .result_valid (result_valid),
    .cmd_err      (cmd_err),
    .timeout      (timeout)
  );

  // Pulse/level counters sampled mid-cycle
  int unsigned n_ki = 0, n_en = 0, n_dn = 0, n_ce = 0, n_sb = 0;
  always @(negedge clk) begin
    if (key_init === 1'b1) n_ki <= n_ki + 1;
    if (enc_next === 1'b1) n_en <= n_en + 1;
    if (dec_next === 1'b1) n_dn <= n_dn + 1;
    if (cmd_err  === 1'b1) n_ce <= n_ce + 1;
    if (sbox_sel === 1'b1) n_sb <= n_sb + 1;
  end

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;
  int unsigned cyc = 0;
  int unsigned t0 = 0;
  int unsigned lat = 0;
  int unsigned s_ki, s_en, s_dn, s_ce, s_sb;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc = cyc + 1;
  endtask

  task automatic snap();
    s_ki = n_ki; s_en = n_en; s_dn = n_dn; s_ce = n_ce; s_sb = n_sb;
  endtask

  task automatic exp_push(input string tag, input logic [31:0] v);
    sb.push_back('{tag, v});
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%0d", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
      end
    end
  endtask

  // Ticks until ready rises or the bound expires; latency 0 marks expiry.
  task automatic wait_ready(input int unsigned bound);
    int unsigned i;
    i = 0;
    while (ready !== 1'b1 && i < bound) begin
      tick();
      i++;
    end
    lat = (ready === 1'b1) ? cyc - t0 : 0;
  endtask

  task automatic reset_checks(input string p);
    exp_push({p, "_ready"}, 1);
    exp_push({p, "_key_valid"}, 0);
    exp_push({p, "_result_valid"}, 0);
    exp_push({p, "_key_init"}, 0);
    exp_push({p, "_enc_next"}, 0);
    exp_push({p, "_dec_next"}, 0);
    exp_push({p, "_cmd_err"}, 0);
    exp_push({p, "_sbox_sel"}, 0);
    exp_push({p, "_keylen_q"}, 0);
    exp_push({p, "_timeout"}, 0);
    chk(ready); chk(key_valid); chk(result_valid); chk(key_init); chk(enc_next);
    chk(dec_next); chk(cmd_err); chk(sbox_sel); chk(keylen_q); chk(timeout);
  endtask

  initial begin
    reset_n = 1'b0; init = 1'b0; next = 1'b0; encdec = 1'b0; keylen = 1'b0;
    key_ready = 1'b0; enc_ready = 1'b0; dec_ready = 1'b0;
    tick(); tick();
    reset_checks("rst");
    reset_n = 1'b1;
    tick();

    // next with no key: rejected
    snap();
    exp_push("t3_cmd_err_pulses", 1);
    exp_push("t3_enc_next", 0);
    exp_push("t3_dec_next", 0);
    exp_push("t3_ready", 1);
    exp_push("t3_key_valid", 0);
    next = 1'b1; encdec = 1'b0;
    tick(); next = 1'b0;
    tick(); tick();
    chk(n_ce - s_ce); chk(n_en - s_en); chk(n_dn - s_dn); chk(ready); chk(key_valid);

    // key expansion, keylen=0, key_ready after 12 cycles
    snap();
    exp_push("t1_key_init_now", 1);
    exp_push("t1_ready_low", 0);
    exp_push("t1_latency", 14);
    exp_push("t1_key_valid", 1);
    exp_push("t1_ready", 1);
    exp_push("t1_keylen_q", 0);
    exp_push("t1_key_init_pulses", 1);
    exp_push("t1_sbox_cycles", 0);
    exp_push("t1_cmd_err_pulses", 0);
    keylen = 1'b0; init = 1'b1;
    tick(); t0 = cyc; init = 1'b0;
    chk(key_init); chk(ready);
    repeat (12) tick();
    key_ready = 1'b1;
    wait_ready(200);
    key_ready = 1'b0;
    chk(lat); chk(key_valid); chk(ready); chk(keylen_q);
    chk(n_ki - s_ki); chk(n_sb - s_sb); chk(n_ce - s_ce);

    // encrypt block
    snap();
    exp_push("t2_enc_next_now", 1);
    exp_push("t2_sbox_sel_start", 1);
    exp_push("t2_ready_low", 0);
    exp_push("t2_result_valid_low", 0);
    exp_push("t2_latency", ENC_WAIT + 2);
    exp_push("t2_sbox_cycles", ENC_WAIT + 1);
    exp_push("t2_enc_next_pulses", 1);
    exp_push("t2_dec_next_pulses", 0);
    exp_push("t2_result_valid", 1);
    exp_push("t2_key_valid", 1);
    exp_push("t2_sbox_sel_after", 0);
    encdec = 1'b1; next = 1'b1;
    tick(); t0 = cyc; next = 1'b0;
    chk(enc_next); chk(sbox_sel); chk(ready); chk(result_valid);
    repeat (ENC_WAIT) tick();
    enc_ready = 1'b1;
    wait_ready(200);
    enc_ready = 1'b0;
    chk(lat); chk(n_sb - s_sb); chk(n_en - s_en); chk(n_dn - s_dn);
    chk(result_valid); chk(key_valid); chk(sbox_sel);

    // init+next together, key_ready already high during guard cycle
    snap();
    exp_push("t4_latency", 3);
    exp_push("t4_key_init_pulses", 1);
    exp_push("t4_cmd_err_pulses", 1);
    exp_push("t4_blk_strobes", 0);
    exp_push("t4_keylen_q", 1);
    exp_push("t4_key_valid", 1);
    exp_push("t4_result_valid_cleared", 0);
    keylen = 1'b1; key_ready = 1'b1; init = 1'b1; next = 1'b1;
    tick(); t0 = cyc; init = 1'b0; next = 1'b0;
    wait_ready(50);
    key_ready = 1'b0;
    chk(lat); chk(n_ki - s_ki); chk(n_ce - s_ce); chk((n_en - s_en) + (n_dn - s_dn));
    chk(keylen_q); chk(key_valid); chk(result_valid);

    // decrypt with init during BLK_WAIT
    snap();
    exp_push("t4b_latency", 5);
    exp_push("t4b_dec_next_pulses", 1);
    exp_push("t4b_enc_next_pulses", 0);
    exp_push("t4b_cmd_err_pulses", 1);
    exp_push("t4b_key_init_pulses", 0);
    exp_push("t4b_sbox_cycles", 0);
    exp_push("t4b_result_valid", 1);
    exp_push("t4b_key_valid", 1);
    exp_push("t4b_keylen_q", 1);
    encdec = 1'b0; next = 1'b1;
    tick(); t0 = cyc; next = 1'b0;
    tick(); init = 1'b1;
    tick(); init = 1'b0;
    tick(); dec_ready = 1'b1;
    wait_ready(50);
    dec_ready = 1'b0;
    chk(lat); chk(n_dn - s_dn); chk(n_en - s_en); chk(n_ce - s_ce);
    chk(n_ki - s_ki); chk(n_sb - s_sb); chk(result_valid); chk(key_valid); chk(keylen_q);

    // async reset in KEY_WAIT
    keylen = 1'b1; init = 1'b1;
    tick(); init = 1'b0;
    tick(); tick();
    reset_n = 1'b0;
    #1;
    reset_checks("t5_async");
    tick(); reset_n = 1'b1;
    snap();
    exp_push("t5_cmd_err_pulses", 1);
    exp_push("t5_blk_strobes", 0);
    exp_push("t5_ready", 1);
    next = 1'b1; encdec = 1'b1;
    tick(); next = 1'b0;
    tick(); tick();
    chk(n_ce - s_ce); chk((n_en - s_en) + (n_dn - s_dn)); chk(ready);

`ifdef AES_CTRL_WDOG_EN
    // watchdog abort in BLK_WAIT
    exp_push("t6_key_valid_setup", 1);
    key_ready = 1'b1; init = 1'b1;
    tick(); t0 = cyc; init = 1'b0;
    wait_ready(50);
    key_ready = 1'b0;
    chk(key_valid);
    exp_push("t6_ready_before", 0);
    exp_push("t6_timeout_before", 0);
    exp_push("t6_latency", 21);
    exp_push("t6_timeout", 1);
    exp_push("t6_result_valid", 0);
    exp_push("t6_key_valid", 1);
    exp_push("t6_timeout_sticky", 1);
    encdec = 1'b0; dec_ready = 1'b0; next = 1'b1;
    tick(); t0 = cyc; next = 1'b0;
    repeat (19) tick();
    chk(ready); chk(timeout);
    wait_ready(50);
    chk(lat); chk(timeout); chk(result_valid); chk(key_valid);
    tick(); tick();
    chk(timeout);
`else
    exp_push("t6_timeout_tied", 0);
    chk(timeout);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
